clock_ctrl: RTL

Clock-enable controller for the 8-bit CPU. It consumes the system clock and produces the single-cycle `cpu_en` strobe that advances every CPU register. Three modes are supported: free-run at a programmable rate, manual single-step from a debounced push-button, and halt driven by the CPU's HLT instruction. It sits between the board clock and the CPU core, and is the consumer and gating end of the divided-rate clock scheme.

---
 rtl/clock_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/clock_ctrl.sv
// clock_ctrl: CPU clock-enable controller.
// Issues a registered one-cycle cpu_en strobe in free-run (programmable rate),
// manual single-step (debounced push-button) or holds it off while halted.
module clock_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] limit,
  input  logic       mode_manual,
  input  logic       step_btn,
  input  logic       hlt,
  input  logic       resume,
  output logic       cpu_en,
  output logic       halted,
  output logic [7:0] pulse_count
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MANUAL,
    ST_HALTED
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_cpu_en;
  logic          r_halted;
  logic [7:0]    r_pulse_count;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic [DW-1:0] r_deb_cnt;
  logic          r_step_req;

  logic          w_rate_hit;

  // A count at or above the limit strobes on this cycle, which also covers
  // the case where limit was lowered beneath the running count.
  assign w_rate_hit = (limit != 4'd0) && (r_cnt >= limit);

  // Step button: 2-flop synchronizer, stability counter, rising-edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_deb      <= 1'b0;
      r_deb_cnt  <= '0;
      r_step_req <= 1'b0;
    end else begin
      r_sync1    <= step_btn;
      r_sync2    <= r_sync1;
      r_step_req <= 1'b0;
      if (r_sync2 == r_deb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_MAX) begin
        r_deb      <= r_sync2;
        r_deb_cnt  <= '0;
        r_step_req <= r_sync2;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

  // Mode FSM, rate counter and registered outputs; hlt overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_cnt         <= '0;
      r_cpu_en      <= 1'b0;
      r_halted      <= 1'b0;
      r_pulse_count <= '0;
    end else begin
      r_cpu_en <= 1'b0;
      if (hlt) begin
        r_state  <= ST_HALTED;
        r_halted <= 1'b1;
        r_cnt    <= '0;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (mode_manual) begin
              r_state <= ST_MANUAL;
              r_cnt   <= '0;
            end else if (w_rate_hit) begin
              r_cpu_en      <= 1'b1;
              r_pulse_count <= r_pulse_count + 8'd1;
              r_cnt         <= '0;
            end else if (limit == 4'd0) begin
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          ST_MANUAL: begin
            if (!mode_manual) begin
              r_state <= ST_RUN;
              r_cnt   <= '0;
            end else if (r_step_req) begin
              r_cpu_en      <= 1'b1;
              r_pulse_count <= r_pulse_count + 8'd1;
            end
          end
          ST_HALTED: begin
            if (resume) begin
              r_state  <= mode_manual ? ST_MANUAL : ST_RUN;
              r_halted <= 1'b0;
              r_cnt    <= '0;
            end
          end
          default: begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
            r_cnt    <= '0;
          end
        endcase
      end
    end
  end

  assign cpu_en      = r_cpu_en;
  assign halted      = r_halted;
  assign pulse_count = r_pulse_count;

endmodule
